// File: rtl/lc3_pkg.sv
// Shared types and encodings for the LC-3 sequencing/decode unit.
// FP1/FP2 exist only when LC3_ISDU_FETCH_PAUSE_EN is defined.
package lc3_pkg;

  localparam logic [3:0] OP_BR    = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_JSR   = 4'b0100;
  localparam logic [3:0] OP_AND   = 4'b0101;
  localparam logic [3:0] OP_LDR   = 4'b0110;
  localparam logic [3:0] OP_STR   = 4'b0111;
  localparam logic [3:0] OP_NOT   = 4'b1001;
  localparam logic [3:0] OP_JMP   = 4'b1100;
  localparam logic [3:0] OP_PAUSE = 4'b1101;

  localparam logic [1:0] ALUK_ADD   = 2'b00;
  localparam logic [1:0] ALUK_AND   = 2'b01;
  localparam logic [1:0] ALUK_NOT   = 2'b10;
  localparam logic [1:0] ALUK_PASSA = 2'b11;

  localparam logic [1:0] PCMUX_PC1   = 2'b00;
  localparam logic [1:0] PCMUX_BUS   = 2'b01;
  localparam logic [1:0] PCMUX_ADDER = 2'b10;

  localparam logic [1:0] ADDR2MUX_ZERO  = 2'b00;
  localparam logic [1:0] ADDR2MUX_OFF6  = 2'b01;
  localparam logic [1:0] ADDR2MUX_OFF9  = 2'b10;
  localparam logic [1:0] ADDR2MUX_OFF11 = 2'b11;

  localparam logic ADDR1MUX_PC  = 1'b0;
  localparam logic ADDR1MUX_REG = 1'b1;

  typedef enum logic [4:0] {
    S_HALTED,
    S_18,
    S_33,
    S_35,
    S_32,
    S_01,
    S_05,
    S_09,
    S_00,
    S_22,
    S_12,
    S_04,
    S_21,
    S_20,
    S_06,
    S_25,
    S_27,
    S_07,
    S_23,
    S_16,
    S_P1,
`ifdef LC3_ISDU_FETCH_PAUSE_EN
    S_P2,
    S_FP1,
    S_FP2
`else
    S_P2
`endif
  } state_t;

  typedef struct packed {
    logic       ld_mar;
    logic       ld_mdr;
    logic       ld_ir;
    logic       ld_ben;
    logic       ld_cc;
    logic       ld_reg;
    logic       ld_pc;
    logic       ld_led;
    logic       gate_pc;
    logic       gate_mdr;
    logic       gate_alu;
    logic       gate_marmux;
    logic [1:0] pcmux;
    logic       drmux;
    logic       sr1mux;
    logic       sr2mux;
    logic       addr1mux;
    logic [1:0] addr2mux;
    logic [1:0] aluk;
    logic       mem_ce_n;
    logic       mem_oe_n;
    logic       mem_we_n;
  } ctrl_t;

  // Everything idle, SRAM strobes deasserted.
  localparam ctrl_t CTRL_IDLE = ctrl_t'(25'h0000007);

  function automatic logic is_mem_state(input state_t s);
    return (s == S_33) || (s == S_25) || (s == S_16);
  endfunction

endpackage

// File: rtl/lc3_mem_wait.sv
// Memory access wait counter: cleared on start, counts while enabled,
// saturates at MEM_WAIT-1 where done is raised.
module lc3_mem_wait
  import lc3_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic start_i,
  input  logic en_i,
  output logic done_o
);

  localparam logic [2:0] LAST = 3'(MEM_WAIT - 1);

  logic [2:0] count_q;
  logic [2:0] count_d;

  assign done_o = (count_q == LAST);

  // Next count: clear on entry, advance only until the last wait cycle.
  always_comb begin
    count_d = count_q;
    if (start_i) begin
      count_d = 3'd0;
    end else if (en_i && !done_o) begin
      count_d = count_q + 3'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= 3'd0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/lc3_isdu.sv
// LC-3 instruction sequencing/decode control FSM (Moore outputs).
// Define LC3_ISDU_FETCH_PAUSE_EN to stop after each fetch and show IR on the LEDs.
module lc3_isdu
  import lc3_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 2
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       IR_11,
  input  logic       BEN,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_CC,
  output logic       LD_REG,
  output logic       LD_PC,
  output logic       LD_LED,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic [1:0] PCMUX,
  output logic       DRMUX,
  output logic       SR1MUX,
  output logic       SR2MUX,
  output logic       ADDR1MUX,
  output logic [1:0] ADDR2MUX,
  output logic [1:0] ALUK,
  output logic       Mem_CE_n,
  output logic       Mem_OE_n,
  output logic       Mem_WE_n
);

  state_t state_q;
  state_t state_d;
  logic   ir5_q;
  logic   ir5_d;
  logic   wait_start_s;
  logic   wait_en_s;
  logic   wait_done_s;
  ctrl_t  ctrl_s;

  assign wait_en_s    = is_mem_state(state_q);
  assign wait_start_s = is_mem_state(state_d) && (state_d != state_q);

  lc3_mem_wait #(
    .MEM_WAIT (MEM_WAIT)
  ) u_mem_wait (
    .clk_i   (Clk),
    .reset_i (reset),
    .start_i (wait_start_s),
    .en_i    (wait_en_s),
    .done_o  (wait_done_s)
  );

  // State and captured immediate-select registers.
  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q <= S_HALTED;
      ir5_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ir5_q   <= ir5_d;
    end
  end

  // IR_5 is sampled at decode so SR2MUX stays a pure function of state.
  always_comb begin
    ir5_d = ir5_q;
    if (state_q == S_32) begin
      ir5_d = IR_5;
    end else begin
      ir5_d = ir5_q;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HALTED: state_d = Run ? S_18 : S_HALTED;
      S_18:     state_d = S_33;
      S_33:     state_d = wait_done_s ? S_35 : S_33;
`ifdef LC3_ISDU_FETCH_PAUSE_EN
      S_35:     state_d = S_FP1;
      S_FP1:    state_d = Continue ? S_FP2 : S_FP1;
      S_FP2:    state_d = Continue ? S_FP2 : S_32;
`else
      S_35:     state_d = S_32;
`endif
      S_32: begin
        case (Opcode)
          OP_ADD:   state_d = S_01;
          OP_AND:   state_d = S_05;
          OP_NOT:   state_d = S_09;
          OP_BR:    state_d = S_00;
          OP_JMP:   state_d = S_12;
          OP_JSR:   state_d = S_04;
          OP_LDR:   state_d = S_06;
          OP_STR:   state_d = S_07;
          OP_PAUSE: state_d = S_P1;
          default:  state_d = S_18;
        endcase
      end
      S_01, S_05, S_09: state_d = S_18;
      S_00:     state_d = BEN ? S_22 : S_18;
      S_22, S_12, S_21, S_20, S_27: state_d = S_18;
      S_04:     state_d = IR_11 ? S_21 : S_20;
      S_06:     state_d = S_25;
      S_25:     state_d = wait_done_s ? S_27 : S_25;
      S_07:     state_d = S_23;
      S_23:     state_d = S_16;
      S_16:     state_d = wait_done_s ? S_18 : S_16;
      S_P1:     state_d = Continue ? S_P2 : S_P1;
      S_P2:     state_d = Continue ? S_P2 : S_18;
      default:  state_d = S_HALTED;
    endcase
  end

  // Output decode from registered state and wait counter only.
  always_comb begin
    ctrl_s = CTRL_IDLE;
    case (state_q)
      S_18: begin
        ctrl_s.gate_pc = 1'b1;
        ctrl_s.ld_mar  = 1'b1;
        ctrl_s.pcmux   = PCMUX_PC1;
        ctrl_s.ld_pc   = 1'b1;
      end
      S_33, S_25: begin
        ctrl_s.mem_ce_n = 1'b0;
        ctrl_s.mem_oe_n = 1'b0;
        ctrl_s.ld_mdr   = wait_done_s;
      end
      S_35: begin
        ctrl_s.gate_mdr = 1'b1;
        ctrl_s.ld_ir    = 1'b1;
      end
      S_32: ctrl_s.ld_ben = 1'b1;
      S_01, S_05, S_09: begin
        ctrl_s.gate_alu = 1'b1;
        ctrl_s.ld_reg   = 1'b1;
        ctrl_s.ld_cc    = 1'b1;
        if (state_q == S_01) begin
          ctrl_s.aluk   = ALUK_ADD;
          ctrl_s.sr2mux = ir5_q;
        end else if (state_q == S_05) begin
          ctrl_s.aluk   = ALUK_AND;
          ctrl_s.sr2mux = ir5_q;
        end else begin
          ctrl_s.aluk   = ALUK_NOT;
          ctrl_s.sr2mux = 1'b0;
        end
      end
      S_22: begin
        ctrl_s.addr1mux = ADDR1MUX_PC;
        ctrl_s.addr2mux = ADDR2MUX_OFF9;
        ctrl_s.pcmux    = PCMUX_ADDER;
        ctrl_s.ld_pc    = 1'b1;
      end
      S_12, S_20: begin
        ctrl_s.sr1mux   = 1'b1;
        ctrl_s.addr1mux = ADDR1MUX_REG;
        ctrl_s.addr2mux = ADDR2MUX_ZERO;
        ctrl_s.pcmux    = PCMUX_ADDER;
        ctrl_s.ld_pc    = 1'b1;
      end
      S_04: begin
        ctrl_s.gate_pc = 1'b1;
        ctrl_s.drmux   = 1'b1;
        ctrl_s.ld_reg  = 1'b1;
      end
      S_21: begin
        ctrl_s.addr2mux = ADDR2MUX_OFF11;
        ctrl_s.addr1mux = ADDR1MUX_PC;
        ctrl_s.pcmux    = PCMUX_ADDER;
        ctrl_s.ld_pc    = 1'b1;
      end
      S_06, S_07: begin
        ctrl_s.gate_marmux = 1'b1;
        ctrl_s.addr2mux    = ADDR2MUX_OFF6;
        ctrl_s.addr1mux    = ADDR1MUX_REG;
        ctrl_s.ld_mar      = 1'b1;
      end
      S_27: begin
        ctrl_s.gate_mdr = 1'b1;
        ctrl_s.ld_reg   = 1'b1;
        ctrl_s.ld_cc    = 1'b1;
      end
      S_23: begin
        ctrl_s.aluk     = ALUK_PASSA;
        ctrl_s.gate_alu = 1'b1;
        ctrl_s.ld_mdr   = 1'b1;
      end
      S_16: begin
        ctrl_s.mem_ce_n = 1'b0;
        ctrl_s.mem_we_n = 1'b0;
      end
      S_P1: ctrl_s.ld_led = 1'b1;
`ifdef LC3_ISDU_FETCH_PAUSE_EN
      S_FP1: ctrl_s.ld_led = 1'b1;
`endif
      default: ctrl_s = CTRL_IDLE;
    endcase
  end

  assign LD_MAR     = ctrl_s.ld_mar;
  assign LD_MDR     = ctrl_s.ld_mdr;
  assign LD_IR      = ctrl_s.ld_ir;
  assign LD_BEN     = ctrl_s.ld_ben;
  assign LD_CC      = ctrl_s.ld_cc;
  assign LD_REG     = ctrl_s.ld_reg;
  assign LD_PC      = ctrl_s.ld_pc;
  assign LD_LED     = ctrl_s.ld_led;
  assign GatePC     = ctrl_s.gate_pc;
  assign GateMDR    = ctrl_s.gate_mdr;
  assign GateALU    = ctrl_s.gate_alu;
  assign GateMARMUX = ctrl_s.gate_marmux;
  assign PCMUX      = ctrl_s.pcmux;
  assign DRMUX      = ctrl_s.drmux;
  assign SR1MUX     = ctrl_s.sr1mux;
  assign SR2MUX     = ctrl_s.sr2mux;
  assign ADDR1MUX   = ctrl_s.addr1mux;
  assign ADDR2MUX   = ctrl_s.addr2mux;
  assign ALUK       = ctrl_s.aluk;
  assign Mem_CE_n   = ctrl_s.mem_ce_n;
  assign Mem_OE_n   = ctrl_s.mem_oe_n;
  assign Mem_WE_n   = ctrl_s.mem_we_n;

endmodule

// File: tb/tb_lc3_isdu.sv
// Directed bench for lc3_isdu: instance 0 uses MEM_WAIT=2, instance 1 MEM_WAIT=3;
// the idle instance is held in reset and checked as HALTED.
module tb_lc3_isdu;

  typedef enum int {
    X_IDLE, X_S18, X_MEMRD, X_MEMRD_LAST, X_S35, X_S32, X_ADD_I, X_AND_R, X_NOT,
    X_S22, X_S12, X_S04, X_S21, X_S20, X_S06, X_S27, X_S23, X_S16, X_P1
  } exp_e;

  logic       clk_s = 1'b0;
  logic [1:0] rst_s;
  logic       run_s, cont_s, ir5_s, ir11_s, ben_s;
  logic [3:0] opcode_s;

  logic ld_mar_s [2], ld_mdr_s [2], ld_ir_s [2], ld_ben_s [2];
  logic ld_cc_s [2], ld_reg_s [2], ld_pc_s [2], ld_led_s [2];
  logic gate_pc_s [2], gate_mdr_s [2], gate_alu_s [2], gate_marmux_s [2];
  logic drmux_s [2], sr1mux_s [2], sr2mux_s [2], addr1mux_s [2];
  logic ce_n_s [2], oe_n_s [2], we_n_s [2];
  logic [1:0] pcmux_s [2], addr2mux_s [2], aluk_s [2];
  logic [24:0] word_s [2];

  int errors_cnt = 0;
  int checks_cnt = 0;

  always #5 clk_s = ~clk_s;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int unsigned MW = (g == 0) ? 2 : 3;
    lc3_isdu #(.MEM_WAIT(MW)) u_dut (
      .Clk(clk_s), .reset(rst_s[g]), .Run(run_s), .Continue(cont_s),
      .Opcode(opcode_s), .IR_5(ir5_s), .IR_11(ir11_s), .BEN(ben_s),
      .LD_MAR(ld_mar_s[g]), .LD_MDR(ld_mdr_s[g]), .LD_IR(ld_ir_s[g]),
      .LD_BEN(ld_ben_s[g]), .LD_CC(ld_cc_s[g]), .LD_REG(ld_reg_s[g]),
      .LD_PC(ld_pc_s[g]), .LD_LED(ld_led_s[g]),
      .GatePC(gate_pc_s[g]), .GateMDR(gate_mdr_s[g]), .GateALU(gate_alu_s[g]),
      .GateMARMUX(gate_marmux_s[g]), .PCMUX(pcmux_s[g]), .DRMUX(drmux_s[g]),
      .SR1MUX(sr1mux_s[g]), .SR2MUX(sr2mux_s[g]), .ADDR1MUX(addr1mux_s[g]),
      .ADDR2MUX(addr2mux_s[g]), .ALUK(aluk_s[g]),
      .Mem_CE_n(ce_n_s[g]), .Mem_OE_n(oe_n_s[g]), .Mem_WE_n(we_n_s[g])
    );
    assign word_s[g] = {ld_mar_s[g], ld_mdr_s[g], ld_ir_s[g], ld_ben_s[g],
                        ld_cc_s[g], ld_reg_s[g], ld_pc_s[g], ld_led_s[g],
                        gate_pc_s[g], gate_mdr_s[g], gate_alu_s[g], gate_marmux_s[g],
                        pcmux_s[g], drmux_s[g], sr1mux_s[g], sr2mux_s[g], addr1mux_s[g],
                        addr2mux_s[g], aluk_s[g], ce_n_s[g], oe_n_s[g], we_n_s[g]};
  end

  // Fields: loads {MAR,MDR,IR,BEN,CC,REG,PC,LED}, gates {PC,MDR,ALU,MARMUX},
  // PCMUX, sels {DRMUX,SR1MUX,SR2MUX,ADDR1MUX}, ADDR2MUX, ALUK, strobes {CE,OE,WE}.
  function automatic logic [24:0] mk(input logic [7:0] ld, input logic [3:0] gt,
                                     input logic [1:0] pcm, input logic [3:0] sel,
                                     input logic [1:0] a2, input logic [1:0] alu,
                                     input logic [2:0] mem);
    return {ld, gt, pcm, sel, a2, alu, mem};
  endfunction

  function automatic logic [24:0] exp_word(input exp_e e);
    case (e)
      X_S18:        return mk(8'b1000_0010, 4'b1000, 2'b00, 4'b0000, 2'b00, 2'b00, 3'b111);
      X_MEMRD:      return mk(8'b0000_0000, 4'b0000, 2'b00, 4'b0000, 2'b00, 2'b00, 3'b001);
      X_MEMRD_LAST: return mk(8'b0100_0000, 4'b0000, 2'b00, 4'b0000, 2'b00, 2'b00, 3'b001);
      X_S35:        return mk(8'b0010_0000, 4'b0100, 2'b00, 4'b0000, 2'b00, 2'b00, 3'b111);
      X_S32:        return mk(8'b0001_0000, 4'b0000, 2'b00, 4'b0000, 2'b00, 2'b00, 3'b111);
      X_ADD_I:      return mk(8'b0000_1100, 4'b0010, 2'b00, 4'b0010, 2'b00, 2'b00, 3'b111);
      X_AND_R:      return mk(8'b0000_1100, 4'b0010, 2'b00, 4'b0000, 2'b00, 2'b01, 3'b111);
      X_NOT:        return mk(8'b0000_1100, 4'b0010, 2'b00, 4'b0000, 2'b00, 2'b10, 3'b111);
      X_S22:        return mk(8'b0000_0010, 4'b0000, 2'b10, 4'b0000, 2'b10, 2'b00, 3'b111);
      X_S12:        return mk(8'b0000_0010, 4'b0000, 2'b10, 4'b0101, 2'b00, 2'b00, 3'b111);
      X_S04:        return mk(8'b0000_0100, 4'b1000, 2'b00, 4'b1000, 2'b00, 2'b00, 3'b111);
      X_S21:        return mk(8'b0000_0010, 4'b0000, 2'b10, 4'b0000, 2'b11, 2'b00, 3'b111);
      X_S20:        return mk(8'b0000_0010, 4'b0000, 2'b10, 4'b0101, 2'b00, 2'b00, 3'b111);
      X_S06:        return mk(8'b1000_0000, 4'b0001, 2'b00, 4'b0001, 2'b01, 2'b00, 3'b111);
      X_S27:        return mk(8'b0000_1100, 4'b0100, 2'b00, 4'b0000, 2'b00, 2'b00, 3'b111);
      X_S23:        return mk(8'b0100_0000, 4'b0010, 2'b00, 4'b0000, 2'b00, 2'b11, 3'b111);
      X_S16:        return mk(8'b0000_0000, 4'b0000, 2'b00, 4'b0000, 2'b00, 2'b00, 3'b010);
      X_P1:         return mk(8'b0000_0001, 4'b0000, 2'b00, 4'b0000, 2'b00, 2'b00, 3'b111);
      default:      return mk(8'b0000_0000, 4'b0000, 2'b00, 4'b0000, 2'b00, 2'b00, 3'b111);
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [24:0] got, input logic [24:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // One clock, then compare the active instance and confirm the other is idle.
  task automatic step(input int inst, input string tag, input exp_e e);
    @(posedge clk_s);
    #1;
    check_eq(tag, word_s[inst], exp_word(e));
    check_eq({tag, "/other"}, word_s[1 - inst], exp_word(X_IDLE));
  endtask

  task automatic mem_rd(input int inst, input int mw, input string tag);
    for (int i = 0; i < mw - 1; i++) step(inst, {tag, "_rd"}, X_MEMRD);
    step(inst, {tag, "_rdlast"}, X_MEMRD_LAST);
  endtask

  task automatic fetch_tail(input int inst, input int mw, input string tag);
    mem_rd(inst, mw, {tag, "_s33"});
    step(inst, {tag, "_s35"}, X_S35);
    step(inst, {tag, "_s32"}, X_S32);
  endtask

  initial begin
    rst_s = 2'b11; run_s = 1'b0; cont_s = 1'b0; opcode_s = 4'b0000;
    ir5_s = 1'b0; ir11_s = 1'b0; ben_s = 1'b0;
    step(0, "rst_halt", X_IDLE);
    rst_s[0] = 1'b0;
    step(0, "halt_norun", X_IDLE);
    run_s = 1'b1;
    step(0, "run_s18", X_S18);
    step(0, "s33_c0", X_MEMRD);
    rst_s[0] = 1'b1;
    step(0, "mid_rst", X_IDLE);
    rst_s[0] = 1'b0; opcode_s = 4'b0001; ir5_s = 1'b1;
    step(0, "add_s18", X_S18);
    run_s = 1'b0;
    fetch_tail(0, 2, "add");
    step(0, "add_s01", X_ADD_I);
    step(0, "add_s18b", X_S18);

    rst_s = 2'b01;
    step(1, "swap_halt", X_IDLE);
    opcode_s = 4'b0000; run_s = 1'b1;
    step(1, "br1_s18", X_S18);
    run_s = 1'b0;
    fetch_tail(1, 3, "br1");
    ben_s = 1'b1;
    step(1, "br1_s00", X_IDLE);
    step(1, "br1_s22", X_S22);
    ben_s = 1'b0;
    step(1, "br0_s18", X_S18);
    fetch_tail(1, 3, "br0");
    step(1, "br0_s00", X_IDLE);
    step(1, "br0_s18b", X_S18);

    opcode_s = 4'b0111; run_s = 1'b1;
    fetch_tail(1, 3, "str");
    step(1, "str_s07", X_S06);
    step(1, "str_s23", X_S23);
    for (int i = 0; i < 3; i++) step(1, "str_s16", X_S16);
    step(1, "str_s18", X_S18);
    run_s = 1'b0;

    opcode_s = 4'b0110;
    fetch_tail(1, 3, "ldr");
    step(1, "ldr_s06", X_S06);
    mem_rd(1, 3, "ldr_s25");
    step(1, "ldr_s27", X_S27);
    step(1, "ldr_s18", X_S18);

    opcode_s = 4'b0101; ir5_s = 1'b0;
    fetch_tail(1, 3, "and");
    step(1, "and_s05", X_AND_R);
    step(1, "and_s18", X_S18);

    opcode_s = 4'b1001; ir5_s = 1'b1;
    fetch_tail(1, 3, "not");
    step(1, "not_s09", X_NOT);
    step(1, "not_s18", X_S18);

    opcode_s = 4'b1100;
    fetch_tail(1, 3, "jmp");
    step(1, "jmp_s12", X_S12);
    step(1, "jmp_s18", X_S18);

    opcode_s = 4'b0100; ir11_s = 1'b1;
    fetch_tail(1, 3, "jsr");
    step(1, "jsr_s04", X_S04);
    step(1, "jsr_s21", X_S21);
    step(1, "jsr_s18", X_S18);
    ir11_s = 1'b0;
    fetch_tail(1, 3, "jsrr");
    step(1, "jsrr_s04", X_S04);
    step(1, "jsrr_s20", X_S20);
    step(1, "jsrr_s18", X_S18);

    opcode_s = 4'b1101; cont_s = 1'b0;
    fetch_tail(1, 3, "pause");
    for (int i = 0; i < 5; i++) step(1, "pause_p1", X_P1);
    cont_s = 1'b1;
    step(1, "pause_p2", X_IDLE);
    step(1, "pause_p2hold", X_IDLE);
    cont_s = 1'b0;
    step(1, "pause_s18", X_S18);

    opcode_s = 4'b1111;
    fetch_tail(1, 3, "nop");
    step(1, "nop_s18", X_S18);

    $display("Result: errors=%0d of %0d checks", errors_cnt, checks_cnt);
    $finish;
  end

endmodule
